// File: rtl/cgb_palette_ctrl.sv
// CGB palette controller: BG/OBJ palette RAMs behind FF68-FF6B plus a two-stage RGB555 lookup.
// Defining PALETTE_DMG_COMPAT_EN adds DMG shade remapping of the colour index in S1.
module cgb_palette_ctrl (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        ff68,
    input  logic        ff69,
    input  logic        ff6a,
    input  logic        ff6b,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        mode3,
    input  logic        dmg_mode,
    input  logic [7:0]  bgp_d,
    input  logic [7:0]  obp0_d,
    input  logic [7:0]  obp1_d,
    input  logic        px_req,
    input  logic        px_obj,
    input  logic [2:0]  px_pal,
    input  logic [1:0]  px_idx,
    output logic [14:0] rgb,
    output logic        rgb_valid
);

    logic       wr_q;
    logic       commit;
    logic       bcps_ai;
    logic       ocps_ai;
    logic [5:0] bcps_addr;
    logic [5:0] ocps_addr;
    logic [7:0] bg_mem  [64];
    logic [7:0] obj_mem [64];

    logic       s1_valid;
    logic       s1_obj;
    logic [5:0] s1_base;
    logic [5:0] hi_addr;
    logic [2:0] eff_pal;
    logic [1:0] eff_idx;

    assign commit = cpu_wr && !wr_q;

    // The auto-increment happens even when mode3 blocks the data write.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q      <= 1'b0;
            bcps_ai   <= 1'b0;
            bcps_addr <= 6'd0;
            ocps_ai   <= 1'b0;
            ocps_addr <= 6'd0;
            bg_mem    <= '{default: 8'hFF};
            obj_mem   <= '{default: 8'hFF};
        end else begin
            wr_q <= cpu_wr;
            if (commit) begin
                if (ff68) begin
                    bcps_ai   <= d_in[7];
                    bcps_addr <= d_in[5:0];
                end
                if (ff69) begin
                    if (!mode3) bg_mem[bcps_addr] <= d_in;
                    if (bcps_ai) bcps_addr <= bcps_addr + 6'd1;
                end
                if (ff6a) begin
                    ocps_ai   <= d_in[7];
                    ocps_addr <= d_in[5:0];
                end
                if (ff6b) begin
                    if (!mode3) obj_mem[ocps_addr] <= d_in;
                    if (ocps_ai) ocps_addr <= ocps_addr + 6'd1;
                end
            end
        end
    end

    always_comb begin
        d_oe  = cpu_rd && (ff68 || ff69 || ff6a || ff6b);
        d_out = 8'h00;
        if (d_oe) begin
            if (ff68)      d_out = {bcps_ai, 1'b1, bcps_addr};
            else if (ff69) d_out = mode3 ? 8'hFF : bg_mem[bcps_addr];
            else if (ff6a) d_out = {ocps_ai, 1'b1, ocps_addr};
            else           d_out = mode3 ? 8'hFF : obj_mem[ocps_addr];
        end
    end

`ifdef PALETTE_DMG_COMPAT_EN
    function automatic logic [1:0] shade_of(input logic [7:0] pal_reg, input logic [1:0] idx);
        case (idx)
            2'd0:    shade_of = pal_reg[1:0];
            2'd1:    shade_of = pal_reg[3:2];
            2'd2:    shade_of = pal_reg[5:4];
            default: shade_of = pal_reg[7:6];
        endcase
    endfunction

    always_comb begin
        eff_pal = px_pal;
        eff_idx = px_idx;
        if (dmg_mode) begin
            if (!px_obj) begin
                eff_pal = 3'd0;
                eff_idx = shade_of(bgp_d, px_idx);
            end else begin
                eff_pal = {2'b00, px_pal[0]};
                eff_idx = shade_of(px_pal[0] ? obp1_d : obp0_d, px_idx);
            end
        end
    end
`else
    logic unused_dmg;
    assign unused_dmg = ^{dmg_mode, bgp_d, obp0_d, obp1_d};

    always_comb begin
        eff_pal = px_pal;
        eff_idx = px_idx;
    end
`endif

    // Each colour is two bytes; the high byte is always the odd address.
    assign hi_addr = {s1_base[5:1], 1'b1};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_valid  <= 1'b0;
            s1_obj    <= 1'b0;
            s1_base   <= 6'd0;
            rgb       <= 15'd0;
            rgb_valid <= 1'b0;
        end else begin
            s1_valid  <= px_req;
            s1_obj    <= px_obj;
            s1_base   <= {eff_pal, eff_idx, 1'b0};
            rgb_valid <= s1_valid;
            if (s1_valid) begin
                rgb <= s1_obj ? {obj_mem[hi_addr][6:0], obj_mem[s1_base]}
                              : {bg_mem[hi_addr][6:0], bg_mem[s1_base]};
            end
        end
    end

endmodule

// File: tb/tb_cgb_palette_ctrl.sv
// Self-checking bench for cgb_palette_ctrl against a byte-array model of the palette RAMs.
// Expectations follow PALETTE_DMG_COMPAT_EN when the bench is built with it defined.
module tb_cgb_palette_ctrl;

    logic        clk;
    logic        nreset;
    logic        cpu_wr, cpu_rd;
    logic        ff68, ff69, ff6a, ff6b;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        mode3;
    logic        dmg_mode;
    logic [7:0]  bgp_d, obp0_d, obp1_d;
    logic        px_req, px_obj;
    logic [2:0]  px_pal;
    logic [1:0]  px_idx;
    logic [14:0] rgb;
    logic        rgb_valid;

    int checks = 0;
    int passes = 0;

    // model state: unit 0 = BG, unit 1 = OBJ
    logic [7:0] m_mem [2][64];
    logic       m_ai   [2];
    logic [5:0] m_addr [2];

    cgb_palette_ctrl dut (
        .clk(clk), .nreset(nreset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .ff68(ff68), .ff69(ff69), .ff6a(ff6a), .ff6b(ff6b),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .mode3(mode3),
        .dmg_mode(dmg_mode), .bgp_d(bgp_d), .obp0_d(obp0_d), .obp1_d(obp1_d),
        .px_req(px_req), .px_obj(px_obj), .px_pal(px_pal), .px_idx(px_idx),
        .rgb(rgb), .rgb_valid(rgb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int s);
        ff68 = (s == 0);
        ff69 = (s == 1);
        ff6a = (s == 2);
        ff6b = (s == 3);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 64; a++) m_mem[u][a] = 8'hFF;
            m_ai[u]   = 1'b0;
            m_addr[u] = 6'd0;
        end
    endtask

    task automatic model_commit(input int s, input logic [7:0] d, input logic m3);
        int u;
        u = s / 2;
        if (s % 2 == 0) begin
            m_ai[u]   = d[7];
            m_addr[u] = d[5:0];
        end else begin
            if (!m3) m_mem[u][m_addr[u]] = d;
            if (m_ai[u]) m_addr[u] = m_addr[u] + 6'd1;
        end
    endtask

    function automatic logic [7:0] model_read(input int s);
        int u;
        u = s / 2;
        if (s % 2 == 0) return {m_ai[u], 1'b1, m_addr[u]};
        if (mode3) return 8'hFF;
        return m_mem[u][m_addr[u]];
    endfunction

    function automatic logic [14:0] model_rgb(input logic obj, input logic [2:0] pal, input logic [1:0] idx);
        int p, i, u;
        logic [5:0] b;
        logic [7:0] lo, hi;
`ifdef PALETTE_DMG_COMPAT_EN
        logic [7:0] sh;
`endif
        p = pal;
        i = idx;
        u = obj ? 1 : 0;
`ifdef PALETTE_DMG_COMPAT_EN
        if (dmg_mode) begin
            if (!obj) begin
                sh = bgp_d;
                p  = 0;
            end else begin
                sh = pal[0] ? obp1_d : obp0_d;
                p  = pal[0] ? 1 : 0;
            end
            i = (sh >> (2 * i)) & 3;
        end
`endif
        b  = 6'(p * 8 + i * 2);
        lo = m_mem[u][b];
        hi = m_mem[u][b + 6'd1];
        return {hi[6:0], lo};
    endfunction

    task automatic cpu_write(input int s, input logic [7:0] d, input int hold);
        set_sel(s);
        d_in   = d;
        cpu_wr = 1'b1;
        repeat (hold) tick();
        model_commit(s, d, mode3);
        cpu_wr = 1'b0;
        set_sel(-1);
        tick();
    endtask

    task automatic check_read(input int s, input string name);
        logic [7:0] exp;
        set_sel(s);
        cpu_rd = 1'b1;
        @(negedge clk);
        exp = model_read(s);
        checks++;
        if (d_out !== exp || d_oe !== 1'b1)
            $display("FAIL %s: d_out=%h d_oe=%b, expected d_out=%h d_oe=1", name, d_out, d_oe, exp);
        else passes++;
        cpu_rd = 1'b0;
        set_sel(-1);
        tick();
    endtask

    task automatic lookup_check(input logic obj, input logic [2:0] pal, input logic [1:0] idx, input string name);
        logic [14:0] exp;
        px_req = 1'b1; px_obj = obj; px_pal = pal; px_idx = idx;
        exp = model_rgb(obj, pal, idx);
        tick();
        px_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb_valid !== 1'b0)
            $display("FAIL %s_early: rgb_valid=%b one edge after request, expected 0", name, rgb_valid);
        else passes++;
        tick();
        @(negedge clk);
        checks++;
        if (rgb_valid !== 1'b1 || rgb !== exp)
            $display("FAIL %s: rgb=%h valid=%b, expected rgb=%h valid=1", name, rgb, rgb_valid, exp);
        else passes++;
        tick();
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++;
        if (rgb !== 15'd0 || rgb_valid !== 1'b0)
            $display("FAIL reset_rgb: rgb=%h valid=%b, expected 0000/0", rgb, rgb_valid);
        else passes++;
        set_sel(1);
        #1;
        checks++;
        if (d_out !== 8'h00 || d_oe !== 1'b0)
            $display("FAIL no_read_bus: d_out=%h d_oe=%b, expected 00/0", d_out, d_oe);
        else passes++;
        set_sel(-1);
        nreset = 1'b1;
        tick();
        check_read(0, "reset_bcps");
        check_read(2, "reset_ocps");
        check_read(1, "reset_bcpd");
        lookup_check(1'b0, 3'd0, 2'd0, "reset_lookup");
    endtask

    task automatic test_autoinc_wrap();
        cpu_write(0, 8'hBE, 3);
        cpu_write(1, 8'h1F, 3);
        cpu_write(1, 8'h00, 3);
        cpu_write(1, 8'hE0, 3);
        check_read(0, "wrap_bcps");
        cpu_write(0, 8'h3E, 1);
        check_read(1, "wrap_mem62");
        cpu_write(0, 8'h3F, 1);
        check_read(1, "wrap_mem63");
        cpu_write(0, 8'h00, 1);
        check_read(1, "wrap_mem0");
    endtask

    task automatic test_mode3_lock();
        cpu_write(2, 8'h88, 1);
        mode3 = 1'b1;
        cpu_write(3, 8'h55, 2);
        check_read(2, "lock_ocps_inc");
        check_read(3, "lock_read_ff");
        mode3 = 1'b0;
        cpu_write(2, 8'h08, 1);
        check_read(3, "lock_mem8");
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_a, exp_b;
        cpu_write(2, 8'h9C, 1);
        cpu_write(3, 8'h1F, 1);
        cpu_write(3, 8'h7C, 1);
        exp_a = model_rgb(1'b1, 3'd3, 2'd2);
        exp_b = model_rgb(1'b1, 3'd0, 2'd0);
        px_req = 1'b1; px_obj = 1'b1; px_pal = 3'd3; px_idx = 2'd2;
        tick();
        px_pal = 3'd0; px_idx = 2'd0;
        tick();
        px_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb !== exp_a || rgb_valid !== 1'b1)
            $display("FAIL b2b_first: rgb=%h valid=%b, expected %h/1", rgb, rgb_valid, exp_a);
        else passes++;
        tick();
        checks++;
        if (rgb !== exp_b || rgb_valid !== 1'b1)
            $display("FAIL b2b_second: rgb=%h valid=%b, expected %h/1", rgb, rgb_valid, exp_b);
        else passes++;
        tick();
        checks++;
        if (rgb_valid !== 1'b0)
            $display("FAIL b2b_bubble: rgb_valid=%b, expected 0", rgb_valid);
        else passes++;
    endtask

    task automatic test_collision();
        logic [14:0] exp_old, exp_new;
        cpu_write(0, 8'h00, 1);
        exp_old = model_rgb(1'b0, 3'd0, 2'd0);
        px_req = 1'b1; px_obj = 1'b0; px_pal = 3'd0; px_idx = 2'd0;
        tick();
        set_sel(1);
        d_in   = 8'h00;
        cpu_wr = 1'b1;
        tick();
        model_commit(1, 8'h00, mode3);
        exp_new = model_rgb(1'b0, 3'd0, 2'd0);
        cpu_wr = 1'b0;
        set_sel(-1);
        px_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb !== exp_old || rgb_valid !== 1'b1)
            $display("FAIL collide_old: rgb=%h valid=%b, expected %h/1", rgb, rgb_valid, exp_old);
        else passes++;
        tick();
        checks++;
        if (rgb !== exp_new || rgb_valid !== 1'b1)
            $display("FAIL collide_new: rgb=%h valid=%b, expected %h/1", rgb, rgb_valid, exp_new);
        else passes++;
        tick();
    endtask

    task automatic test_dmg();
        cpu_write(0, 8'h86, 1);
        cpu_write(1, 8'h11, 1);
        cpu_write(1, 8'h22, 1);
        cpu_write(0, 8'h96, 1);
        cpu_write(1, 8'h33, 1);
        cpu_write(1, 8'h44, 1);
        cpu_write(2, 8'h88, 1);
        cpu_write(3, 8'hAA, 1);
        cpu_write(3, 8'h55, 1);
        dmg_mode = 1'b1;
        bgp_d    = 8'hE4;
        obp0_d   = 8'hFF;
        obp1_d   = 8'h1B;
        lookup_check(1'b0, 3'd2, 2'd3, "dmg_bg");
        lookup_check(1'b1, 3'd5, 2'd3, "dmg_obj");
        dmg_mode = 1'b0;
    endtask

    task automatic test_burst();
        logic        req_q [32];
        logic [14:0] exp_q [32];
        px_req = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 30; c++) begin
            req_q[c] = (c < 26) ? 1'($urandom_range(0, 1)) : 1'b0;
            px_req = req_q[c];
            px_obj = 1'($urandom);
            px_pal = 3'($urandom);
            px_idx = 2'($urandom);
            exp_q[c] = model_rgb(px_obj, px_pal, px_idx);
            tick();
            if (c >= 1) begin
                checks++;
                if (rgb_valid !== req_q[c-1] || (req_q[c-1] && rgb !== exp_q[c-1]))
                    $display("FAIL burst_%0d: rgb=%h valid=%b, expected %h/%b", c - 1, rgb, rgb_valid, exp_q[c-1], req_q[c-1]);
                else passes++;
            end
        end
        px_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int op, s;
        for (int n = 0; n < 120; n++) begin
            op    = $urandom_range(0, 2);
            s     = $urandom_range(0, 3);
            mode3 = ($urandom_range(0, 3) == 0);
            if (op == 0) cpu_write(s, 8'($urandom), $urandom_range(1, 3));
            else if (op == 1) check_read(s, $sformatf("rand_read_%0d", n));
            else lookup_check(1'($urandom), 3'($urandom), 2'($urandom), $sformatf("rand_lookup_%0d", n));
        end
        mode3 = 1'b0;
    endtask

    task automatic test_reset_midstream();
        px_req = 1'b1; px_obj = 1'b0; px_pal = 3'd1; px_idx = 2'd1;
        tick();
        tick();
        #2;
        nreset = 1'b0;
        px_req = 1'b0;
        #1;
        checks++;
        if (rgb_valid !== 1'b0)
            $display("FAIL midreset_async: rgb_valid=%b, expected 0", rgb_valid);
        else passes++;
        model_reset();
        tick();
        nreset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (rgb_valid !== 1'b0)
                $display("FAIL midreset_flush_%0d: rgb_valid=%b, expected 0", c, rgb_valid);
            else passes++;
        end
        check_read(0, "midreset_bcps");
        lookup_check(1'b0, 3'd1, 2'd1, "midreset_lookup");
    endtask

    initial begin
        nreset = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        ff68 = 1'b0; ff69 = 1'b0; ff6a = 1'b0; ff6b = 1'b0;
        d_in = 8'h00; mode3 = 1'b0; dmg_mode = 1'b0;
        bgp_d = 8'h00; obp0_d = 8'h00; obp1_d = 8'h00;
        px_req = 1'b0; px_obj = 1'b0; px_pal = 3'd0; px_idx = 2'd0;
        test_reset();
        test_autoinc_wrap();
        test_mode3_lock();
        test_back_to_back();
        test_collision();
        test_dmg();
        test_burst();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cgb_palette_ctrl.md
# cgb_palette_ctrl

Colour palette controller for the CGB-style colour path: owns the 64-byte BG and 64-byte OBJ palette memories behind FF68–FF6B. It arbitrates CPU index/data accesses against the PPU pixel-lookup pipeline, and turns each 2-bit colour index into an RGB555 word. It sits between the CPU data bus and the pixel output, and feeds the LCD driver in place of the DMG shade path.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `cpu_wr`  in  1  CPU write strobe (level); commit on first cycle high.
- `cpu_rd`  in  1  CPU read strobe (level).
- `ff68`, `ff69`, `ff6a`, `ff6b`  in  1 each  decoded register selects: BCPS, BCPD, OCPS, OCPD.
- `d_in`  in  8  CPU write data.
- `d_out`  out  8  CPU read data.
- `d_oe`  out  1  drive enable for `d_out`.
- `mode3`  in  1  PPU pixel-transfer active; locks CPU palette data access.
- `dmg_mode`  in  1  DMG compatibility lookup select (used only under the macro in Configuration).
- `bgp_d`, `obp0_d`, `obp1_d`  in  8 each  DMG palette register contents (used only under the macro).
- `px_req`  in  1  PPU lookup request, one pixel per cycle.
- `px_obj`  in  1  0 = BG palette memory, 1 = OBJ palette memory.
- `px_pal`  in  3  palette number 0–7.
- `px_idx`  in  2  colour index 0–3.
- `rgb`  out  15  {B[4:0], G[4:0], R[4:0]}.
- `rgb_valid`  out  1  `rgb` valid this cycle.

## Operation
- Index registers BCPS and OCPS each hold `ai` (bit 7) and `addr[5:0]`. Reads return {ai, 1, addr}.
- Write commit:
  - A write is taken on the first cycle `cpu_wr` is high; `wr_q` holds the previous `cpu_wr`.
  - Commit = `cpu_wr && !wr_q`.
  - A held strobe commits exactly once.
- Index write (FF68 or FF6A): `ai` ← `d_in[7]`, `addr` ← `d_in[5:0]`. `d_in[6]` is ignored.
- Data write (FF69 or FF6B):
  - If `!mode3`: mem[addr] ← `d_in`.
  - Independent of `mode3`: if `ai`, addr ← (addr+1) mod 64, wrapping 63→0.
- Data read (FF69 or FF6B): `d_out` = mem[addr] when `!mode3`, else 0xFF. Reads never increment.
- `d_oe` = `cpu_rd && (ff68|ff69|ff6a|ff6b)`. When `d_oe` is low, `d_out` = 0x00.
- Lookup pipeline:
  - S1 registers the byte address, base = px_pal*8 + px_idx*2, together with `px_obj` and a valid bit.
  - S2 reads the low byte mem[base] and the high byte mem[base+1], then registers `rgb` = {hi[6:0], lo[7:0]} and `rgb_valid`.
  - The pipeline accepts a new request every cycle. A bubble in `px_req` gives a bubble in `rgb_valid`.
- Collision: when a CPU commit and an S2 read hit the same byte in the same cycle, the lookup returns the old value (read-before-write).

## Timing
- Reset (async, while `nreset` low):
  - both index registers = 0x00, `wr_q` = 0;
  - all 128 memory bytes = 0xFF;
  - S1/S2 cleared, `rgb` = 0, `rgb_valid` = 0;
  - `d_out` = 0x00.
- Lookup latency: request at edge N gives `rgb_valid` high after edge N+2.
- CPU write becomes visible to reads, and to lookups entering S2, one cycle after the commit edge.
- `mode3` is sampled on the commit edge. A `mode3` rise in the same cycle blocks the write; the increment still occurs.
- Reset asserted mid-stream: in-flight lookups are discarded, with no `rgb_valid` after deassert until a new `px_req`.

## Configuration
- `PALETTE_DMG_COMPAT_EN` defined: when `dmg_mode` = 1, S1 remaps the colour index before addressing:
  - BG: idx' = bgp_d[2*idx+1 : 2*idx], palette forced to 0.
  - OBJ: the shade comes from `obp0_d` when px_pal[0] = 0, else from `obp1_d`; palette forced to px_pal[0].
  - Latency is unchanged.
- Macro not defined: `dmg_mode`, `bgp_d`, `obp0_d` and `obp1_d` are ignored; lookup always uses `px_pal`/`px_idx` directly.

## Test plan
- Reset, then read FF68 → 0x40. Lookup BG pal 0 idx 0 → `rgb` = 0x7FFF, valid 2 cycles after `px_req`.
- Write FF68 = 0xBE, then FF69 = 0x1F, 0x00, 0xE0 (strobes each held 3 cycles) → mem[62] = 0x1F, mem[63] = 0x00, mem[0] = 0xE0; final FF68 read = 0xC1.
- Set OCPS = 0x88, `mode3` = 1, write FF6B = 0x55 → mem[8] unchanged at 0xFF, OCPS reads 0xC9, FF6B read returns 0xFF.
- Load OBJ pal 3 idx 2 with 0x1F, 0x7C. Issue back-to-back lookups on pal 3 idx 2 then pal 0 idx 0 → `rgb` = 0x7C1F then 0x7FFF on consecutive cycles.
- Same-cycle CPU commit of 0x00 to the byte being read by S2 → that lookup returns the old value; the next lookup returns the new value.
- With `PALETTE_DMG_COMPAT_EN`, `dmg_mode` = 1, bgp_d = 0xE4, BG idx 3 → address of pal 0 idx 3 (bytes 6–7). Without the macro → address of px_pal idx 3.
